// File: rtl/data_memory_block.sv
// Word-organised 64 x 32-bit data memory behind the data cache. Every block
// read or write stalls the requester for a fixed LATENCY of busy cycles.
module data_memory_block #(
   parameter int unsigned LATENCY = 5
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [5:0]  mem_address,
   input  logic [31:0] mem_writedata,
   output logic [31:0] mem_readdata,
   output logic        mem_busywait
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

   state_t      state;
   state_t      next_state;
   logic [3:0]  counter;
   logic [5:0]  addr_q;
   logic [31:0] wdata_q;
   logic        op_write;
   logic [31:0] mem [64];

   logic request;
   assign request = mem_read | mem_write;

   // NOTE: registers take non-blocking assignments so every flop samples
   // pre-edge values, independent of the order the processes are evaluated.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   // NOTE: next_state gets a default before the case so no path infers a latch.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (request) next_state = BUSY;
         BUSY:    if (counter == 4'd0) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      mem_busywait = 1'b0;
      unique case (state)
         IDLE:    mem_busywait = request;
         BUSY:    mem_busywait = 1'b1;
         default: mem_busywait = 1'b0;
      endcase
   end

   // NOTE: the array sits on the async reset because it must power up as all
   // zeros; that forces flops rather than a RAM macro.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         counter      <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         op_write     <= 1'b0;
         mem_readdata <= '0;
         for (int i = 0; i < 64; i++) mem[i] <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (request) begin
                  addr_q   <= mem_address;
                  wdata_q  <= mem_writedata;
                  op_write <= mem_write;
                  counter  <= COUNT_LOAD;
               end
            end
            BUSY: begin
               if (counter != 4'd0) begin
                  counter <= counter - 4'd1;
               end else if (op_write) begin
                  mem[addr_q] <= wdata_q;
               end else begin
                  mem_readdata <= mem[addr_q];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_block.sv
// Directed self-checking bench for data_memory_block at LATENCY=5; inputs are
// driven and outputs sampled around the falling clock edge.
module tb_data_memory_block;

   logic        clock = 1'b0;
   logic        reset;
   logic        mem_read;
   logic        mem_write;
   logic [5:0]  mem_address;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;
   logic        mem_busywait;

   int checks = 0;
   int errors = 0;

   data_memory_block #(.LATENCY(5)) dut (
      .clock         (clock),
      .reset         (reset),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_address   (mem_address),
      .mem_writedata (mem_writedata),
      .mem_readdata  (mem_readdata),
      .mem_busywait  (mem_busywait)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Raise a request at a falling edge and count busy cycles until busywait
   // drops (DONE). The request stays asserted on return, as a requester would.
   task automatic access(input logic rd, input logic wr, input logic [5:0] addr,
                         input logic [5:0] churn_addr, input logic [31:0] wdata,
                         output int busy, output logic [31:0] rdata);
      @(negedge clock);
      mem_read      = rd;
      mem_write     = wr;
      mem_address   = addr;
      mem_writedata = wdata;
      busy = 0;
      #1;
      while (mem_busywait && busy < 40) begin
         busy++;
         if (busy == 2) begin
            mem_address   = churn_addr;
            mem_writedata = ~wdata;
         end
         @(negedge clock);
         #1;
      end
      rdata = mem_readdata;
   endtask

   task automatic idle();
      @(negedge clock);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      #1;
   endtask

   int          busy;
   logic [31:0] rdata;

   initial begin
      reset = 1'b0;
      mem_read = 1'b0;
      mem_write = 1'b0;
      mem_address = '0;
      mem_writedata = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("reset_readdata", mem_readdata, 32'h0);
      check("reset_busywait", {31'b0, mem_busywait}, 32'h0);

      access(1'b1, 1'b0, 6'h3F, 6'h3F, 32'h0, busy, rdata);
      check("read3f_busy", busy, 6);
      check("read3f_data", rdata, 32'h0);
      idle();

      access(1'b0, 1'b1, 6'h05, 6'h05, 32'hDEADBEEF, busy, rdata);
      check("write05_busy", busy, 6);
      check("write05_rdata_held", rdata, 32'h0);
      idle();
      check("idle_busywait", {31'b0, mem_busywait}, 32'h0);

      access(1'b1, 1'b0, 6'h05, 6'h05, 32'h0, busy, rdata);
      check("read05_busy", busy, 6);
      check("read05_data", rdata, 32'hDEADBEEF);
      idle();
      repeat (3) @(negedge clock);
      check("read05_held", mem_readdata, 32'hDEADBEEF);

      // Write-back immediately followed by a fetch, no idle gap.
      access(1'b0, 1'b1, 6'h2A, 6'h2A, 32'h11223344, busy, rdata);
      check("wb2a_busy", busy, 6);
      access(1'b1, 1'b0, 6'h0A, 6'h0A, 32'h0, busy, rdata);
      check("fetch0a_busy", busy, 6);
      check("fetch0a_data", rdata, 32'h0);
      access(1'b1, 1'b0, 6'h2A, 6'h2A, 32'h0, busy, rdata);
      check("read2a_data", rdata, 32'h11223344);
      idle();

      // Address churn during BUSY must not redirect the read.
      access(1'b0, 1'b1, 6'h01, 6'h01, 32'hA5A5A5A5, busy, rdata);
      access(1'b0, 1'b1, 6'h02, 6'h02, 32'h5A5A5A5A, busy, rdata);
      access(1'b1, 1'b0, 6'h01, 6'h02, 32'h0, busy, rdata);
      check("churn_busy", busy, 6);
      check("churn_data", rdata, 32'hA5A5A5A5);
      idle();

      // Read and write together: write wins, readdata untouched.
      access(1'b1, 1'b1, 6'h10, 6'h10, 32'h0000FFFF, busy, rdata);
      check("rw10_busy", busy, 6);
      check("rw10_rdata_held", rdata, 32'hA5A5A5A5);
      access(1'b1, 1'b0, 6'h10, 6'h10, 32'h0, busy, rdata);
      check("read10_data", rdata, 32'h0000FFFF);
      idle();

      // Reset pulse in the third BUSY cycle of a write.
      @(negedge clock);
      mem_write     = 1'b1;
      mem_address   = 6'h07;
      mem_writedata = 32'hCAFEF00D;
      repeat (3) @(negedge clock);
      #1;
      reset     = 1'b0;
      mem_write = 1'b0;
      #1;
      check("midrst_busywait", {31'b0, mem_busywait}, 32'h0);
      check("midrst_readdata", mem_readdata, 32'h0);
      #1;
      reset = 1'b1;
      access(1'b1, 1'b0, 6'h07, 6'h07, 32'h0, busy, rdata);
      check("midrst_read07_busy", busy, 6);
      check("midrst_read07_data", rdata, 32'h0);
      access(1'b1, 1'b0, 6'h05, 6'h05, 32'h0, busy, rdata);
      check("midrst_read05_cleared", rdata, 32'h0);
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_memory_block.md
# data_memory_block

Word-organised data memory: 64 blocks × 32 bits. It sits directly downstream of the data cache and serves the cache controller's block fetches and write-backs over the mem_read / mem_write / mem_busywait handshake. Each access has a fixed, parameterised multi-cycle latency, which models main-memory delay. The block always holds its requester stalled until read data is registered or the write is committed.

## Interface
- LATENCY, 5: number of BUSY cycles per access; legal range 1..15.
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
- mem_read  in  1  block read request; held by requester until it sees mem_busywait=0.
- mem_write  in  1  block write request; same holding rule.
- mem_address  in  6  block address (index into 64-entry array).
- mem_writedata  in  32  block write data.
- mem_readdata  out  32  registered read data.
- mem_busywait  out  1  stall to requester.

## Operation
- Storage: 64 × 32-bit array; 4-bit latency counter; 2-bit state; latched address, write data and operation (op).
- States: IDLE, BUSY, DONE.
- IDLE:
  - mem_read|mem_write at a posedge: latch mem_address, mem_writedata and op. Op is write if mem_write=1 (write wins when both are high), else read. Load counter = LATENCY-1, go to BUSY.
  - Neither request: stay in IDLE.
- BUSY:
  - Counter>0 at posedge: decrement.
  - Counter==0 at posedge: perform access and go to DONE.
    - Read: mem_readdata <= array[latched address].
    - Write: array[latched address] <= latched write data.
  - Input changes during BUSY are ignored; only latched values are used.
- DONE: unconditionally go to IDLE at the next posedge. Requests are ignored here, because the requester still drives its request during this cycle.
- mem_busywait is combinational: 1 when (state==IDLE and (mem_read|mem_write)) or state==BUSY; 0 otherwise (IDLE with no request, or DONE).
- mem_readdata changes only on read completion or reset. It holds its value through writes and idle periods.
- A read of an address written earlier returns the written data. There are no byte enables; accesses are always whole words.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, counter=0, mem_readdata=0, all 64 array words=0. mem_busywait follows its combinational equation, so it is 0 when no request is present.
- Reset asserted mid-access: the access is aborted; a pending write is not committed and mem_readdata returns to 0.
- Request first visible in cycle 0 (IDLE): mem_busywait=1 in cycles 0..LATENCY. The access commits at the posedge ending cycle LATENCY. mem_busywait=0 and mem_readdata is valid from cycle LATENCY+1 (DONE).
- LATENCY=5: busywait high for 6 cycles, data valid in cycle 6.
- Back-to-back use: the requester drops a request in the cycle after DONE, or raises a new one (for example a cache write-back followed immediately by a fetch). A new request seen in the IDLE cycle after DONE starts a fresh access with no gap; busywait rises combinationally in that same cycle.
- A request deasserted before completion: the access still completes as latched; busywait follows its equation.
- Address wrap: the 6-bit address covers 0..63 exactly; there is no out-of-range case.

## Test plan
- Reset: hold reset=0 for 2 cycles, release, no request → mem_readdata=0x00000000, mem_busywait=0; a read of address 0x3F returns 0x00000000.
- Single write then read (LATENCY=5): write 0xDEADBEEF to address 0x05 → busywait high for exactly 6 cycles. Then read 0x05 → busywait high for 6 cycles, and mem_readdata=0xDEADBEEF in cycle 6, held afterward.
- Write-back then fetch, as the cache controller performs it: write 0x11223344 to 0x2A. In the cycle after DONE, read 0x0A without an idle gap → both accesses take 6 busy cycles; mem_readdata=0 (reset value of 0x0A); array[0x2A]=0x11223344.
- Input churn: read 0x01 (preloaded 0xA5A5A5A5), change mem_address to 0x02 during BUSY → returns 0xA5A5A5A5.
- Simultaneous read+write to 0x10 with data 0x0000FFFF → treated as write; mem_readdata unchanged; a later read of 0x10 returns 0x0000FFFF.
- Reset mid-write: start write 0xCAFEF00D to 0x07 and pulse reset=0 in the third BUSY cycle → state returns to IDLE, and a subsequent read of 0x07 returns 0x00000000.
